// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, opcodes and the sequencer state type.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;

  localparam logic [2:0] OPC_ADD  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_LOAD   = 3'd2,
    SEQ_ISSUE  = 3'd3,
    SEQ_EXEC   = 3'd4,
    SEQ_HALTED = 3'd5,
    SEQ_FAULT  = 3'd6
  } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Execution watchdog: cleared at issue, counts while enabled, flags the last allowed cycle.
module seq_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_r;

  // Counter holds at the expiry value; the FSM leaves EXEC at that point anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != CW'(TIMEOUT - 1))) begin
      count_r <= count_r + 1'b1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches from synchronous RAM, issues each instruction with a start
// pulse over the start/waiting handshake, retires it and stops on HALT or watchdog timeout.
module instr_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_val,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               start,
  input  logic               waiting,
  output logic [ADDR_W-1:0]  pc,
  output logic [CNT_W-1:0]   retired,
  output logic               busy,
  output logic               halted,
  output logic               fault
);

  import cpu_pkg::*;

  seq_state_t         state_r, state_next_s;
  logic [ADDR_W-1:0]  pc_r, pc_next_s;
  logic [INSTR_W-1:0] ir_r, ir_next_s;
  logic [CNT_W-1:0]   retired_r, retired_next_s;
  logic               seen_low_r, seen_low_next_s;
  logic               start_r, busy_r, halted_r, fault_r;
  logic               wd_clear_s, wd_enable_s, wd_expire_s;
  logic               done_s;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear_s),
    .enable (wd_enable_s),
    .expire (wd_expire_s)
  );

  // Completion needs waiting to have dropped first, so a stale "idle" is not taken as done.
  assign done_s = waiting && seen_low_r;

  // Next-state, PC, IR and retire-count logic.
  always_comb begin
    state_next_s    = state_r;
    pc_next_s       = pc_r;
    ir_next_s       = ir_r;
    retired_next_s  = retired_r;
    seen_low_next_s = seen_low_r;
    wd_clear_s      = 1'b0;
    wd_enable_s     = 1'b0;
    case (state_r)
      SEQ_IDLE: begin
        if (pc_load) begin
          pc_next_s = pc_load_val;
        end else if (run && waiting) begin
          state_next_s = SEQ_FETCH;
        end else begin
          state_next_s = SEQ_IDLE;
        end
      end
      SEQ_FETCH: begin
        state_next_s = SEQ_LOAD;
      end
      SEQ_LOAD: begin
        ir_next_s = mem_rdata;
        if (mem_rdata[OPC_MSB:OPC_LSB] == OPC_HALT) begin
          state_next_s = SEQ_HALTED;
        end else begin
          state_next_s = SEQ_ISSUE;
        end
      end
      SEQ_ISSUE: begin
        wd_clear_s      = 1'b1;
        seen_low_next_s = 1'b0;
        state_next_s    = SEQ_EXEC;
      end
      SEQ_EXEC: begin
        wd_enable_s = 1'b1;
        if (!waiting) begin
          seen_low_next_s = 1'b1;
        end else begin
          seen_low_next_s = seen_low_r;
        end
        if (done_s) begin
          pc_next_s = pc_r + 1'b1;
          if (&retired_r) begin
            retired_next_s = retired_r;
          end else begin
            retired_next_s = retired_r + 1'b1;
          end
          state_next_s = run ? SEQ_FETCH : SEQ_IDLE;
        end else if (wd_expire_s) begin
          state_next_s = SEQ_FAULT;
        end else begin
          state_next_s = SEQ_EXEC;
        end
      end
      SEQ_HALTED, SEQ_FAULT: begin
        if (pc_load) begin
          pc_next_s    = pc_load_val;
          state_next_s = SEQ_IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = SEQ_IDLE;
      end
    endcase
  end

  // State and datapath registers; status outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= SEQ_IDLE;
      pc_r       <= '0;
      ir_r       <= '0;
      retired_r  <= '0;
      seen_low_r <= 1'b0;
      start_r    <= 1'b0;
      busy_r     <= 1'b0;
      halted_r   <= 1'b0;
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      pc_r       <= pc_next_s;
      ir_r       <= ir_next_s;
      retired_r  <= retired_next_s;
      seen_low_r <= seen_low_next_s;
      start_r    <= (state_next_s == SEQ_ISSUE);
      busy_r     <= (state_next_s == SEQ_FETCH) || (state_next_s == SEQ_LOAD) ||
                    (state_next_s == SEQ_ISSUE) || (state_next_s == SEQ_EXEC);
      halted_r   <= (state_next_s == SEQ_HALTED);
      fault_r    <= (state_next_s == SEQ_FAULT);
    end
  end

  assign mem_addr = pc_r;
  assign pc       = pc_r;
  assign instr    = ir_r;
  assign retired  = retired_r;
  assign start    = start_r;
  assign busy     = busy_r;
  assign halted   = halted_r;
  assign fault    = fault_r;

endmodule
